i2s_tdm_serializer: RTL

Parametrised multi-channel audio serializer and the successor to the single-word shift register on the DAC path. Accepts one audio frame (NUM_CH samples) per valid/ready handshake into a one-deep holding register. Generates SCLK and LRCLK/frame-sync from Clk and shifts the frame out MSB-first in I2S (NUM_CH=2) or TDM (NUM_CH>2) format. Streams zeros and flags underrun when no frame is ready, so the codec always receives data.

---
 rtl/i2s_tdm_serializer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/i2s_tdm_serializer.sv
// I2S/TDM audio serializer: one-deep frame holding register, SCLK/LRCLK generation, MSB-first shift-out.
// Optional macro I2S_LEFT_JUSTIFIED_EN removes the one-bit I2S data delay (MSB aligned with the LRCLK edge).
module i2s_tdm_serializer #(
    parameter int D_WIDTH = 24,
    parameter int SLOT_W  = 32,
    parameter int NUM_CH  = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Enable,
    input  logic [NUM_CH*D_WIDTH-1:0] In_Data,
    input  logic                      In_Valid,
    output logic                      In_Ready,
    output logic                      Sclk_Out,
    output logic                      Lrclk_Out,
    output logic                      Sd_Out,
    output logic                      Frame_Start,
    output logic                      Underrun
);

    localparam int FRAME_BITS = NUM_CH * SLOT_W;
    localparam int SR_W       = FRAME_BITS + 1;
    localparam int DATA_W     = NUM_CH * D_WIDTH;
    localparam int CNT_W      = $clog2(CLK_DIV);
    localparam int P_W        = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [P_W-1:0]   P_LAST   = P_W'(FRAME_BITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [P_W-1:0]        p_q, p_d;
    logic                  sclk_q, sclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underrun_q, underrun_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic [DATA_W-1:0]     hold_q, hold_d;
    logic [SR_W-1:0]       sr_q, sr_d;
    logic [SR_W-1:0]       sr_shift;
    logic [FRAME_BITS-1:0] frame_vec;
    logic                  accept;
    logic                  bit_tick;
    logic                  frame_load;

    assign accept     = In_Valid && in_ready_q;
    assign bit_tick   = Enable && (cnt_q == CNT_LAST);
    assign frame_load = bit_tick && (p_q == '0);
    assign sr_shift   = {sr_q[SR_W-2:0], 1'b0};

    // Lay the held samples out in wire order: slot s MSB-first, padded with zeros to SLOT_W.
    always_comb begin
        frame_vec = '0;
        for (int s = 0; s < NUM_CH; s++) begin
            for (int j = 0; j < D_WIDTH; j++) begin
                frame_vec[FRAME_BITS-1-(s*SLOT_W+j)] = hold_q[s*D_WIDTH+D_WIDTH-1-j];
            end
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        p_d           = p_q;
        sclk_d        = sclk_q;
        lrclk_d       = lrclk_q;
        sr_d          = sr_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;

        if (frame_load && hold_valid_q) begin
            hold_valid_d = 1'b0;
        end
        // Accept can only happen with the holding register empty, so it never collides with a take.
        if (accept) begin
            hold_d       = In_Data;
            hold_valid_d = 1'b1;
        end

        if (!Enable) begin
            cnt_d   = '0;
            p_d     = '0;
            sclk_d  = 1'b0;
            lrclk_d = 1'b0;
            sr_d    = '0;
        end else begin
            cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_RISE) begin
                sclk_d = 1'b1;
            end
            if (bit_tick) begin
                sclk_d = 1'b0;
                sr_d   = sr_shift;
                // Top bit keeps the previous frame's last bit so it still appears in the delay slot.
                if (frame_load) begin
                    sr_d          = {sr_shift[SR_W-1], hold_valid_q ? frame_vec : {FRAME_BITS{1'b0}}};
                    frame_start_d = 1'b1;
                    underrun_d    = !hold_valid_q;
                end
                if (NUM_CH == 2) begin
                    lrclk_d = (p_q >= P_W'(SLOT_W));
                end else begin
                    lrclk_d = (p_q == '0);
                end
                p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
            end
        end

        in_ready_d = !hold_valid_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q         <= '0;
            p_q           <= '0;
            sclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sr_q          <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            cnt_q         <= cnt_d;
            p_q           <= p_d;
            sclk_q        <= sclk_d;
            lrclk_q       <= lrclk_d;
            sr_q          <= sr_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign In_Ready    = in_ready_q;
    assign Sclk_Out    = sclk_q;
    assign Lrclk_Out   = lrclk_q;
    assign Frame_Start = frame_start_q;
    assign Underrun    = underrun_q;

`ifdef I2S_LEFT_JUSTIFIED_EN
    assign Sd_Out = sr_q[SR_W-2];
`else
    assign Sd_Out = sr_q[SR_W-1];
`endif

endmodule
